toast_mem_model: RTL and testbench

- Parametrised, synthesizable-style dual-port memory model for ToastCore simulation and FPGA bring-up.
- Instruction port is read-only. Data port is read/write with byte enables.
- Read latency is configurable. Out-of-range accesses are flagged.
- Includes a tohost-style end-of-test status machine (RUNNING/PASS/FAIL) so benches detect test completion without probing core internals.

---
 rtl/toast_mem_model.sv | 147 ++++++++++++++
 tb/tb_toast_mem_model.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/toast_mem_model.sv
// Dual-port word memory for ToastCore simulation and bring-up, with a pipelined read path and a tohost end-of-test status machine.
// Optional macro TOAST_MEM_UNIMP_HALT_EN: an unimp (32'hC000_1073) fetch while RUNNING forces FAIL.
module toast_mem_model #(
  parameter int unsigned DEPTH_WORDS  = 2048,
  parameter int unsigned READ_LATENCY = 1,
  parameter logic [31:0] TOHOST_ADDR  = 32'h0000_1000,
  parameter string       INIT_FILE    = ""
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        I_req,
  input  logic [31:0] I_addr,
  output logic        I_rvalid,
  output logic [31:0] I_rdata,
  input  logic        D_req,
  input  logic        D_we,
  input  logic [3:0]  D_be,
  input  logic [31:0] D_addr,
  input  logic [31:0] D_wdata,
  output logic        D_rvalid,
  output logic [31:0] D_rdata,
  output logic        Err,
  output logic        Done,
  output logic        Pass,
  output logic [30:0] Fail_code
);

  localparam int AW  = $clog2(DEPTH_WORDS);
  localparam int PD  = 3;
  localparam int TAP = (READ_LATENCY > 1) ? int'(READ_LATENCY) - 2 : 0;

  typedef enum logic [1:0] {ST_RUN, ST_PASS, ST_FAIL} state_t;

  logic [31:0] mem [DEPTH_WORDS];

  initial begin
    for (int w = 0; w < int'(DEPTH_WORDS); w++) mem[w] = '0;
  end

  logic [AW-1:0] i_idx, d_idx;
  logic          i_ok, d_ok, d_rd, d_wr, tohost_wr, unimp_hit;
  logic [31:0]   i_word, d_word;

  assign i_idx     = I_addr[AW+1:2];
  assign d_idx     = D_addr[AW+1:2];
  assign i_ok      = (I_addr[31:AW+2] == '0);
  assign d_ok      = (D_addr[31:AW+2] == '0);
  assign d_rd      = D_req & ~D_we;
  assign d_wr      = D_req & D_we & d_ok;
  assign i_word    = i_ok ? mem[i_idx] : '0;
  assign d_word    = d_ok ? mem[d_idx] : '0;
  assign tohost_wr = D_req & D_we & (D_be == 4'hF) & (D_addr[31:2] == TOHOST_ADDR[31:2]);

`ifdef TOAST_MEM_UNIMP_HALT_EN
  assign unimp_hit = I_rvalid & (I_rdata == 32'hC000_1073);
`else
  assign unimp_hit = 1'b0;
`endif

  // Array write: no reset, and reads above sample the pre-write contents.
  always @(posedge Clk) begin
    if (d_wr) begin
      for (int b = 0; b < 4; b++) begin
        if (D_be[b]) mem[d_idx][8*b +: 8] <= D_wdata[8*b +: 8];
      end
    end
  end

  logic        i_vld_p  [PD];
  logic [31:0] i_data_p [PD];
  logic        d_vld_p  [PD];
  logic [31:0] d_data_p [PD];

  logic        i_tap_vld, d_tap_vld;
  logic [31:0] i_tap_data, d_tap_data;

  // Latency 1 bypasses the intermediate stages; otherwise tap stage READ_LATENCY-2.
  assign i_tap_vld  = (READ_LATENCY == 1) ? I_req  : i_vld_p[TAP];
  assign i_tap_data = (READ_LATENCY == 1) ? i_word : i_data_p[TAP];
  assign d_tap_vld  = (READ_LATENCY == 1) ? d_rd   : d_vld_p[TAP];
  assign d_tap_data = (READ_LATENCY == 1) ? d_word : d_data_p[TAP];

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int k = 0; k < PD; k++) begin
        i_vld_p[k]  <= 1'b0;
        i_data_p[k] <= '0;
        d_vld_p[k]  <= 1'b0;
        d_data_p[k] <= '0;
      end
      I_rvalid <= 1'b0;
      I_rdata  <= '0;
      D_rvalid <= 1'b0;
      D_rdata  <= '0;
      Err      <= 1'b0;
    end else begin
      // stage p0: capture the addressed word on the request edge
      i_vld_p[0]  <= I_req;
      i_data_p[0] <= i_word;
      d_vld_p[0]  <= d_rd;
      d_data_p[0] <= d_word;
      // stages p1..: pure delay line
      for (int k = 1; k < PD; k++) begin
        i_vld_p[k]  <= i_vld_p[k-1];
        i_data_p[k] <= i_data_p[k-1];
        d_vld_p[k]  <= d_vld_p[k-1];
        d_data_p[k] <= d_data_p[k-1];
      end
      // output stage: rdata only moves with a valid pulse
      I_rvalid <= i_tap_vld;
      D_rvalid <= d_tap_vld;
      if (i_tap_vld) I_rdata <= i_tap_data;
      if (d_tap_vld) D_rdata <= d_tap_data;
      if ((I_req & ~i_ok) | (D_req & ~d_ok)) Err <= 1'b1;
    end
  end

  state_t state;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state     <= ST_RUN;
      Done      <= 1'b0;
      Pass      <= 1'b0;
      Fail_code <= '0;
    end else if (state == ST_RUN) begin
      if (unimp_hit) begin
        state     <= ST_FAIL;
        Done      <= 1'b1;
        Fail_code <= '1;
      end else if (tohost_wr && D_wdata == 32'd1) begin
        state <= ST_PASS;
        Done  <= 1'b1;
        Pass  <= 1'b1;
      end else if (tohost_wr && D_wdata != 32'd0) begin
        state     <= ST_FAIL;
        Done      <= 1'b1;
        Fail_code <= D_wdata[31:1];
      end
    end
  end

  logic unused_ok;
  assign unused_ok = ^{I_addr[1:0], D_addr[1:0], i_vld_p[PD-1], i_data_p[PD-1],
                       d_vld_p[PD-1], d_data_p[PD-1]};

endmodule

// File: tb/tb_toast_mem_model.sv
// Randomised scoreboard bench for toast_mem_model: two instances (read latency 1 and 3) share stimulus.
module tb_toast_mem_model;

  localparam int          DEPTH  = 2048;
  localparam logic [31:0] TOHOST = 32'h0000_1000;

  logic        Clk = 1'b0;
  logic        Reset_n = 1'b0;
  logic        I_req = 1'b0, D_req = 1'b0, D_we = 1'b0;
  logic [31:0] I_addr = '0, D_addr = '0, D_wdata = '0;
  logic [3:0]  D_be = '0;

  logic        i_rvalid1, d_rvalid1, err1, done1, pass1;
  logic [31:0] i_rdata1, d_rdata1;
  logic [30:0] fc1;
  logic        i_rvalid3, d_rvalid3, err3, done3, pass3;
  logic [31:0] i_rdata3, d_rdata3;
  logic [30:0] fc3;

  toast_mem_model #(.DEPTH_WORDS(DEPTH), .READ_LATENCY(1), .TOHOST_ADDR(TOHOST)) dut1 (
    .Clk(Clk), .Reset_n(Reset_n),
    .I_req(I_req), .I_addr(I_addr), .I_rvalid(i_rvalid1), .I_rdata(i_rdata1),
    .D_req(D_req), .D_we(D_we), .D_be(D_be), .D_addr(D_addr), .D_wdata(D_wdata),
    .D_rvalid(d_rvalid1), .D_rdata(d_rdata1),
    .Err(err1), .Done(done1), .Pass(pass1), .Fail_code(fc1));

  toast_mem_model #(.DEPTH_WORDS(DEPTH), .READ_LATENCY(3), .TOHOST_ADDR(TOHOST)) dut3 (
    .Clk(Clk), .Reset_n(Reset_n),
    .I_req(I_req), .I_addr(I_addr), .I_rvalid(i_rvalid3), .I_rdata(i_rdata3),
    .D_req(D_req), .D_we(D_we), .D_be(D_be), .D_addr(D_addr), .D_wdata(D_wdata),
    .D_rvalid(d_rvalid3), .D_rdata(d_rdata3),
    .Err(err3), .Done(done3), .Pass(pass3), .Fail_code(fc3));

  always #5 Clk = ~Clk;

  typedef struct { logic [31:0] data; int due; } exp_t;

  // Streams: 0 = I/lat1, 1 = D/lat1, 2 = I/lat3, 3 = D/lat3
  exp_t        sb_q [4][$];
  logic [31:0] last_rd [4];
  logic [31:0] mem_m [DEPTH];
  logic        err_m;
  int          st_m;
  logic [30:0] fc_m;
  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;

  always @(posedge Clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic mon(input int s, input logic v, input logic [31:0] d);
    exp_t  e;
    string nm;
    nm = $sformatf("stream%0d", s);
    if (v) begin
      if (sb_q[s].size() == 0) begin
        chk({nm, "_spurious_rvalid"}, 32'(v), 32'd0);
      end else begin
        e = sb_q[s].pop_front();
        chk({nm, "_rdata"}, d, e.data);
        chk({nm, "_arrival_cycle"}, 32'(cyc), 32'(e.due));
      end
      last_rd[s] = d;
    end else begin
      chk({nm, "_rdata_hold"}, d, last_rd[s]);
      if (sb_q[s].size() > 0 && sb_q[s][0].due < cyc) begin
        void'(sb_q[s].pop_front());
        chk({nm, "_rvalid_missing"}, 32'(v), 32'd1);
      end
    end
  endtask

  always @(negedge Clk) begin
    if (Reset_n) begin
      mon(0, i_rvalid1, i_rdata1);
      mon(1, d_rvalid1, d_rdata1);
      mon(2, i_rvalid3, i_rdata3);
      mon(3, d_rvalid3, d_rdata3);
    end
  end

  function automatic logic inr(input logic [31:0] a);
    return a[31:2] < 30'(DEPTH);
  endfunction

  function automatic logic [31:0] rd_m(input logic [31:0] a);
    return inr(a) ? mem_m[int'(a[31:2])] : 32'h0;
  endfunction

  // One clock of stimulus; expectations are formed from the model before this cycle's write lands.
  task automatic step(input logic ir, input logic [31:0] ia, input logic dr, input logic dw,
                      input logic [3:0] be, input logic [31:0] da, input logic [31:0] wd);
    exp_t e;
    I_req = ir; I_addr = ia; D_req = dr; D_we = dw; D_be = be; D_addr = da; D_wdata = wd;
    if (ir) begin
      e.data = rd_m(ia);
      e.due = cyc + 1; sb_q[0].push_back(e);
      e.due = cyc + 3; sb_q[2].push_back(e);
      if (!inr(ia)) err_m = 1'b1;
    end
    if (dr) begin
      if (!inr(da)) err_m = 1'b1;
      if (!dw) begin
        e.data = rd_m(da);
        e.due = cyc + 1; sb_q[1].push_back(e);
        e.due = cyc + 3; sb_q[3].push_back(e);
      end else begin
        if (inr(da)) begin
          for (int b = 0; b < 4; b++)
            if (be[b]) mem_m[int'(da[31:2])][8*b +: 8] = wd[8*b +: 8];
        end
        if (be == 4'hF && da[31:2] == TOHOST[31:2] && st_m == 0) begin
          if (wd == 32'd1) st_m = 1;
          else if (wd != 32'd0) begin st_m = 2; fc_m = wd[31:1]; end
        end
      end
    end
    @(posedge Clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, '0, 1'b0, 1'b0, 4'h0, '0, '0);
  endtask

  task automatic apply_reset();
    I_req = 1'b0; D_req = 1'b0; D_we = 1'b0; D_be = '0;
    Reset_n = 1'b0;
    for (int s = 0; s < 4; s++) begin
      sb_q[s].delete();
      last_rd[s] = '0;
    end
    err_m = 1'b0; st_m = 0; fc_m = '0;
    repeat (3) @(posedge Clk);
    #1 Reset_n = 1'b1;
  endtask

  task automatic check_status(input string nm);
    logic [31:0] fc_exp;
    fc_exp = (st_m == 2) ? {1'b0, fc_m} : 32'h0;
    chk({nm, "_err_lat1"},  32'(err1),  32'(err_m));
    chk({nm, "_err_lat3"},  32'(err3),  32'(err_m));
    chk({nm, "_done_lat1"}, 32'(done1), 32'(st_m != 0));
    chk({nm, "_done_lat3"}, 32'(done3), 32'(st_m != 0));
    chk({nm, "_pass_lat1"}, 32'(pass1), 32'(st_m == 1));
    chk({nm, "_pass_lat3"}, 32'(pass3), 32'(st_m == 1));
    chk({nm, "_fcode_lat1"}, {1'b0, fc1}, fc_exp);
    chk({nm, "_fcode_lat3"}, {1'b0, fc3}, fc_exp);
  endtask

  function automatic logic [31:0] rand_addr();
    int idx;
    if ($urandom_range(0, 15) == 0) return $urandom | 32'h0000_2000;
    idx = $urandom_range(0, DEPTH - 1);
    if (idx == int'(TOHOST[31:2])) idx = idx + 1;
    return (32'(idx) << 2) | 32'($urandom_range(0, 3));
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int total;
    for (int w = 0; w < DEPTH; w++) mem_m[w] = '0;
    apply_reset();
    chk("rst_i_rvalid_lat1", 32'(i_rvalid1), 32'd0);
    chk("rst_d_rvalid_lat3", 32'(d_rvalid3), 32'd0);
    chk("rst_i_rdata_lat1", i_rdata1, 32'd0);
    chk("rst_d_rdata_lat3", d_rdata3, 32'd0);
    check_status("reset");

    // Latency sweep on word 0x40
    step(1'b0, '0, 1'b1, 1'b1, 4'hF, 32'h40, 32'hDEADBEEF);
    step(1'b1, 32'h40, 1'b1, 1'b0, 4'h0, 32'h40, '0);
    idle(4);

    // Byte enables on word 0x80
    step(1'b0, '0, 1'b1, 1'b1, 4'hF, 32'h80, 32'h11223344);
    step(1'b0, '0, 1'b1, 1'b1, 4'b0101, 32'h80, 32'hAABBCCDD);
    step(1'b1, 32'h80, 1'b1, 1'b0, 4'h0, 32'h80, '0);
    step(1'b0, '0, 1'b1, 1'b1, 4'h0, 32'h80, 32'hFFFFFFFF);
    step(1'b1, 32'h83, 1'b1, 1'b0, 4'h0, 32'h81, '0);
    idle(4);

    // Back-to-back reads of words 0, 1, 2
    for (int k = 0; k < 3; k++) step(1'b0, '0, 1'b1, 1'b1, 4'hF, 32'(k * 4), $urandom);
    for (int k = 0; k < 3; k++) step(1'b1, 32'(k * 4), 1'b1, 1'b0, 4'h0, 32'(k * 4), '0);
    idle(4);

    // Read-first collision, then the new value
    step(1'b1, 32'h40, 1'b1, 1'b1, 4'hF, 32'h40, 32'h12345678);
    step(1'b1, 32'h40, 1'b1, 1'b0, 4'h0, 32'h40, '0);
    idle(4);
    check_status("pre_oor");

    // Out-of-range read and write
    step(1'b1, 32'h2000, 1'b1, 1'b0, 4'h0, 32'h2000, '0);
    idle(4);
    check_status("oor_read");
    step(1'b0, '0, 1'b1, 1'b1, 4'hF, 32'h2000, 32'hFFFFFFFF);
    step(1'b0, '0, 1'b1, 1'b1, 4'hF, 32'h0000_2004, 32'hA5A5A5A5);
    idle(2);

    // Random traffic on both ports
    for (int k = 0; k < 400; k++)
      step(1'($urandom), rand_addr(), 1'($urandom), 1'($urandom), 4'($urandom), rand_addr(), $urandom);
    idle(4);
    check_status("random");

    // tohost: partial and zero writes are ignored, then PASS
    step(1'b0, '0, 1'b1, 1'b1, 4'b0111, TOHOST, 32'd1);
    idle(2);
    check_status("tohost_partial");
    step(1'b0, '0, 1'b1, 1'b1, 4'hF, TOHOST, 32'd0);
    idle(2);
    check_status("tohost_zero");
    step(1'b0, '0, 1'b1, 1'b1, 4'hF, TOHOST, 32'd1);
    idle(2);
    check_status("tohost_pass");

    apply_reset();
    check_status("after_reset");
    step(1'b0, '0, 1'b1, 1'b1, 4'hF, TOHOST, 32'd7);
    idle(2);
    check_status("tohost_fail7");
    step(1'b0, '0, 1'b1, 1'b1, 4'hF, TOHOST, 32'd1);
    idle(2);
    check_status("tohost_terminal");
    step(1'b1, TOHOST, 1'b1, 1'b0, 4'h0, TOHOST, '0);
    idle(4);

    // Reset one cycle after a read request; nothing may emerge afterwards
    step(1'b1, 32'h40, 1'b1, 1'b0, 4'h0, 32'h40, '0);
    idle(1);
    apply_reset();
    idle(8);
    step(1'b1, 32'h40, 1'b1, 1'b0, 4'h0, 32'h40, '0);
    idle(4);

    // Full sweep confirms every in-range word, including after out-of-range writes
    for (int w = 0; w < DEPTH; w++)
      step(1'b1, 32'(w * 4), 1'b1, 1'b0, 4'h0, 32'((DEPTH - 1 - w) * 4), '0);
    idle(6);
    check_status("final");

    total = 0;
    for (int s = 0; s < 4; s++) total += sb_q[s].size();
    chk("scoreboard_drained", 32'(total), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
